// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary MAC array: weight codes, readout FSM states
// and default geometry.
package ternary_pkg;

    localparam int DEF_W     = 4;
    localparam int DEF_H     = 16;
    localparam int DEF_ACC_W = 17;
    localparam int DEF_SH_W  = 4;

    localparam logic [1:0] WCODE_ZERO    = 2'b00;
    localparam logic [1:0] WCODE_POS     = 2'b01;
    localparam logic [1:0] WCODE_NEG     = 2'b10;
    localparam logic [1:0] WCODE_NEG_ALT = 2'b11;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_WAIT_APPLY,
        ST_SNAPSHOT,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/ternary_out_stage.sv
// Readout path: arithmetic right shift, saturation to signed 8 bits, optional ReLU.
// Purely combinational; TERNARY_RELU_EN adds the relu_en input.
module ternary_out_stage
    import ternary_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int SH_W  = DEF_SH_W
) (
    input  logic [ACC_W-1:0] acc_val,
    input  logic [SH_W-1:0]  shift_amt,
`ifdef TERNARY_RELU_EN
    input  logic             relu_en,
`endif
    output logic [7:0]       result
);

    localparam logic signed [ACC_W-1:0] S8_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] S8_MIN = ACC_W'(-128);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = $signed(acc_val) >>> shift_amt;
        if (shifted > S8_MAX) begin
            result = 8'h7f;
        end else if (shifted < S8_MIN) begin
            result = 8'h80;
        end else begin
            result = shifted[7:0];
        end
`ifdef TERNARY_RELU_EN
        if (relu_en && result[7]) begin
            result = 8'h00;
        end
`endif
    end

endmodule

// File: rtl/ternary_mac_array.sv
// H x W ternary-weight MAC array: W beats build a vector, applied one column per cycle,
// readout drains W*H shifted/saturated values with valid/ready. Optional ReLU: TERNARY_RELU_EN.
module ternary_mac_array
    import ternary_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int H     = DEF_H,
    parameter int ACC_W = DEF_ACC_W,
    parameter int SH_W  = DEF_SH_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*(H/W)-1:0]   w_in,
    input  logic [7:0]           a_in,
    input  logic                 read_start,
    input  logic [SH_W-1:0]      shift_amt,
`ifdef TERNARY_RELU_EN
    input  logic                 relu_en,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_last
);

    localparam int RPB = H / W;
    localparam int N   = W * H;
    localparam int BW  = (W > 1) ? $clog2(W) : 1;
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(W - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

    state_t state_q, state_d;

    logic [BW-1:0]    beat_cnt;
    logic [BW-1:0]    apply_cnt;
    logic             apply_busy;
    logic [1:0]       stage_w [H];
    logic [7:0]       stage_a [W];
    logic [1:0]       apply_w [H];
    logic [7:0]       apply_a [W];
    logic [ACC_W-1:0] acc     [H][W];
    logic [ACC_W-1:0] out_q   [N];
    logic [IW-1:0]    idx;
    logic [SH_W-1:0]  shift_q;
`ifdef TERNARY_RELU_EN
    logic             relu_q;
`endif

    logic       final_beat;
    logic       apply_blocks;
    logic       accept;
    logic       drain_hs;
    logic [7:0] stage_result;

    function automatic logic [ACC_W-1:0] sext8(input logic [7:0] v);
        return {{(ACC_W-8){v[7]}}, v};
    endfunction

    // The apply buffer can be reloaded in the cycle it finishes its last column,
    // so a final beat only stalls if the previous apply is further behind.
    assign final_beat   = (beat_cnt == LAST_BEAT);
    assign apply_blocks = final_beat && apply_busy && (apply_cnt != LAST_BEAT);
    assign accept       = in_valid && in_ready;
    assign drain_hs     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                in_ready = !apply_blocks;
                if (read_start) begin
                    state_d = ST_WAIT_APPLY;
                end
            end
            ST_WAIT_APPLY: begin
                if (!apply_busy) begin
                    state_d = ST_SNAPSHOT;
                end
            end
            ST_SNAPSHOT: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                in_ready  = !apply_blocks;
                out_valid = 1'b1;
                if (out_ready && (idx == LAST_IDX)) begin
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt   <= '0;
            apply_cnt  <= '0;
            apply_busy <= 1'b0;
            idx        <= '0;
            shift_q    <= '0;
`ifdef TERNARY_RELU_EN
            relu_q     <= 1'b0;
`endif
            for (int i = 0; i < H; i++) begin
                stage_w[i] <= WCODE_ZERO;
                apply_w[i] <= WCODE_ZERO;
                for (int j = 0; j < W; j++) begin
                    acc[i][j]     <= '0;
                    out_q[i*W+j]  <= '0;
                end
            end
            for (int j = 0; j < W; j++) begin
                stage_a[j] <= '0;
                apply_a[j] <= '0;
            end
        end else begin
            if (apply_busy) begin
                for (int i = 0; i < H; i++) begin
                    for (int j = 0; j < W; j++) begin
                        if (int'(apply_cnt) == j) begin
                            if (apply_w[i] == WCODE_POS) begin
                                acc[i][j] <= acc[i][j] + sext8(apply_a[j]);
                            end else if (apply_w[i] == WCODE_NEG || apply_w[i] == WCODE_NEG_ALT) begin
                                acc[i][j] <= acc[i][j] - sext8(apply_a[j]);
                            end
                        end
                    end
                end
                if (apply_cnt == LAST_BEAT) begin
                    apply_busy <= 1'b0;
                    apply_cnt  <= '0;
                end else begin
                    apply_cnt <= apply_cnt + 1'b1;
                end
            end

            // A completed vector is merged with the final beat straight into the
            // apply buffer, overriding the apply counter update above.
            if (accept) begin
                for (int i = 0; i < H; i++) begin
                    if (i / RPB == int'(beat_cnt)) begin
                        stage_w[i] <= w_in[2*(i%RPB) +: 2];
                    end
                end
                for (int j = 0; j < W; j++) begin
                    if (j == int'(beat_cnt)) begin
                        stage_a[j] <= a_in;
                    end
                end
                if (final_beat) begin
                    beat_cnt   <= '0;
                    apply_busy <= 1'b1;
                    apply_cnt  <= '0;
                    for (int i = 0; i < H; i++) begin
                        apply_w[i] <= (i / RPB == W - 1) ? w_in[2*(i%RPB) +: 2] : stage_w[i];
                    end
                    for (int j = 0; j < W; j++) begin
                        apply_a[j] <= (j == W - 1) ? a_in : stage_a[j];
                    end
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end

            // Readout settings are frozen here so out_data cannot move under a stall.
            if (state_q == ST_SNAPSHOT) begin
                shift_q <= shift_amt;
`ifdef TERNARY_RELU_EN
                relu_q  <= relu_en;
`endif
                for (int i = 0; i < H; i++) begin
                    for (int j = 0; j < W; j++) begin
                        out_q[i*W+j] <= acc[i][j];
                        acc[i][j]    <= '0;
                    end
                end
            end

            if (drain_hs) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    ternary_out_stage #(
        .ACC_W (ACC_W),
        .SH_W  (SH_W)
    ) u_out_stage (
        .acc_val   (out_q[idx]),
        .shift_amt (shift_q),
`ifdef TERNARY_RELU_EN
        .relu_en   (relu_q),
`endif
        .result    (stage_result)
    );

    assign out_data = out_valid ? stage_result : 8'd0;
    assign out_last = out_valid && (idx == LAST_IDX);

endmodule

// File: doc/ternary_mac_array.md
TERNARY_MAC_ARRAY -- requirements
Module: ternary_mac_array

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- W, 4: accumulator columns; also beats per input vector.
- H, 16: accumulator rows; H SHALL be a multiple of W.
- ACC_W, 17: accumulator width in bits.
- SH_W, 4: width of shift_amt.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: beat accepted when in_valid and in_ready are both high.
- w_in, in, 2*H/W: H/W packed ternary weights per beat.
- a_in, in, 8: signed activation for this beat.
- read_start, in, 1: request readout.
- shift_amt, in, SH_W: arithmetic right shift applied at readout.
- relu_en, in, 1: ReLU select; present only with TERNARY_RELU_EN.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: output beat consumed when out_valid and out_ready are both high.
- out_data, out, 8: signed readout value.
- out_last, out, 1: marks the final element of a readout.

Function
REQ-003 Weight code per 2-bit field: 00 = 0, 01 = +1, 10 and 11 = -1.
REQ-004 Beat k (0..W-1) SHALL load weights for rows k*H/W .. (k+1)*H/W-1, field 0 = lowest row, and activation column k.
REQ-005 A beat counter SHALL advance on each accepted beat and wrap W-1 -> 0. Wrapping completes a vector.
REQ-006 A completed vector SHALL be latched into an apply buffer. The apply counter then updates column j in cycle j, for j = 0..W-1.
REQ-007 Column update, for every row i: acc[i][j] += a_j if w_i = +1, acc[i][j] -= a_j if w_i = -1, unchanged if w_i = 0. Arithmetic is ACC_W-bit two's complement and wraps with no saturation.
REQ-008 The latency from the final beat of a vector to column 0 being updated SHALL be 1 cycle.
REQ-009 in_ready SHALL be low on the final beat of a vector only while the previous apply is still running. Back-to-back vectors SHALL never stall.
REQ-010 FSM states and transitions:
- ACCUM -> WAIT_APPLY on read_start.
- WAIT_APPLY -> SNAPSHOT when the apply buffer is idle.
- SNAPSHOT -> DRAIN after 1 cycle.
- DRAIN -> ACCUM on the last output handshake.
REQ-011 In SNAPSHOT, all accumulators SHALL be copied to the out queue and cleared in the same cycle.
REQ-012 in_ready SHALL be low in WAIT_APPLY and SNAPSHOT. In DRAIN, input SHALL be accepted into the cleared accumulators, so readout overlaps the next batch.
REQ-013 A partial vector in progress at read_start SHALL be retained and belongs to the next batch.
REQ-014 read_start SHALL be ignored outside ACCUM.
REQ-015 DRAIN SHALL output W*H elements in index order i*W+j.
- out_data = saturate_s8(out_queue[idx] >>> shift_amt).
- out_last SHALL be high with element W*H-1.
REQ-016 out_valid, once high, SHALL hold out_data stable until the handshake. out_ready low SHALL stall the index.

Reset
REQ-017 Reset SHALL set:
- all accumulators, the out queue, the beat counter and the apply counter to 0;
- the apply buffer to empty;
- the FSM to ACCUM;
- in_ready = 1, out_valid = 0, out_data = 0, out_last = 0.
REQ-018 Reset asserted mid-drain or mid-vector SHALL discard all state in that cycle, with no partial output.

Configuration
REQ-019 TERNARY_RELU_EN defined: the relu_en port exists, and when relu_en = 1, negative saturated results SHALL output 0.
REQ-020 TERNARY_RELU_EN undefined: the relu_en port and its logic are absent, and the output is the signed saturated result only.

Structure
REQ-021 A shared package ternary_pkg SHALL hold:
- the weight code constants;
- the FSM state enum;
- the default parameter values.
REQ-022 Sub-module ternary_out_stage SHALL hold the combinational shift, saturate and optional ReLU path.

Verification
REQ-023 Single vector:
- Stimulus: W=4, H=16, all weights +1, a = {10, 20, 30, 40}, then read_start, shift_amt=0.
- Response: 64 outputs repeating 10, 20, 30, 40; out_last on element 63.
REQ-024 Sign and zero codes:
- Stimulus: weights 10, 00, 01 on rows 0..2, a_0 = -5.
- Response: acc[0][0]=5, acc[1][0]=0, acc[2][0]=-5.
REQ-025 Shift and saturation:
- Stimulus: accumulate acc=1000, then read with shift_amt=2.
- Response: 127. With shift_amt=4: 62.
REQ-026 ReLU:
- Stimulus: TERNARY_RELU_EN defined, relu_en=1, acc=-300.
- Response: 0. With relu_en=0: -128.
REQ-027 Overlap and backpressure:
- Stimulus: read_start then continuous input, with out_ready toggling 1/0.
- Response: no lost or duplicated output; the second read reflects only post-snapshot vectors.
REQ-028 Reset during DRAIN:
- Stimulus: assert reset at output element 20.
- Response: out_valid = 0 the next cycle; a fresh read after one all-zero-weight vector returns all zeros.
